// File: rtl/axi_lite_responder_pkg.sv
// Shared AXI-lite types and helpers for the responder memory model.
package axi_lite_responder_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = AXI_OKAY;
  localparam axi_resp_t RESP_SLVERR = AXI_SLVERR;

  // Byte-lane merge of a write beat into an existing word.
  function automatic logic [AXI_DATA_W-1:0] strb_merge(
    input logic [AXI_DATA_W-1:0] old_word,
    input logic [AXI_DATA_W-1:0] new_word,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < AXI_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_responder_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
module axi_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] lfsr_q, lfsr_d;

  // Next value: shift left, feedback from taps 8,6,5,4.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State register; reset loads the (nonzero) seed.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/axi_lite_responder.sv
// AXI-lite slave memory model with fixed or LFSR-driven response delay.
// Independent read and write FSMs, one outstanding transaction each.
module axi_lite_responder
  import axi_lite_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter bit          RAND_DLY  = 1'b1,
  parameter int          FIXED_DLY = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ar_valid_i,
  input  logic [AXI_ADDR_W-1:0] ar_addr_i,
  output logic                  ar_ready_o,
  output logic                  r_valid_o,
  output logic [AXI_DATA_W-1:0] r_data_o,
  output axi_resp_t             r_resp_o,
  input  logic                  r_ready_i,
  input  logic                  aw_valid_i,
  input  logic [AXI_ADDR_W-1:0] aw_addr_i,
  output logic                  aw_ready_o,
  input  logic                  w_valid_i,
  input  logic [AXI_DATA_W-1:0] w_data_i,
  input  logic [AXI_STRB_W-1:0] w_strb_i,
  output logic                  w_ready_o,
  output logic                  b_valid_o,
  output axi_resp_t             b_resp_o,
  input  logic                  b_ready_i
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] SPAN       = 32'(DEPTH * 4);
  localparam logic [3:0]  FIXED_DLY4 = 4'(FIXED_DLY);

  // One-hot state encodings.
  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_WAIT = 3'b010,
    R_RESP = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_DLY  = 3'b010,
    W_RESP = 3'b100
  } wr_state_e;

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];

  // ---------------- delay source and reset-release flag ----------------
  logic [7:0] lfsr;
  logic [3:0] dly;
  logic       unused_lfsr_hi;
  logic       rdy_en_q;

  axi_lfsr8 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  assign dly            = RAND_DLY ? lfsr[3:0] : FIXED_DLY4;
  assign unused_lfsr_hi = ^lfsr[7:4];

  // Ready outputs stay low until one cycle after reset is released.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [3:0]            rd_cnt_q, rd_cnt_d;
  logic [AXI_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [AXI_DATA_W-1:0] r_data_q, r_data_d;
  axi_resp_t             r_resp_q, r_resp_d;
  logic [AXI_ADDR_W-1:0] rd_off;
  logic                  rd_hit;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_capture;

  // A zero delay captures straight from the AR channel, otherwise from the latched address.
  assign rd_off = ((rd_state_q == R_IDLE) ? ar_addr_i : rd_addr_q) - ADDR_BASE;
  assign rd_hit = rd_off < SPAN;
  assign rd_idx = rd_off[IDX_W+1:2];

  assign ar_ready_o = rdy_en_q && (rd_state_q == R_IDLE);
  assign r_valid_o  = (rd_state_q == R_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  // Read next-state: accept AR, count the delay down, hold the response until R handshake.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    rd_capture = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_valid_i && ar_ready_o) begin
          rd_addr_d = ar_addr_i;
          rd_cnt_d  = dly;
          if (dly == 4'd0) begin
            rd_capture = 1'b1;
            rd_state_d = R_RESP;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q <= 4'd1) begin
          rd_capture = 1'b1;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (r_ready_i) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    // Data is sampled here, so a write committing this same cycle is not seen.
    if (rd_capture) begin
      r_data_d = rd_hit ? mem_q[rd_idx] : '0;
      r_resp_d = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read path registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [3:0]            wr_cnt_q, wr_cnt_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
  logic [AXI_STRB_W-1:0] w_strb_q, w_strb_d;
  axi_resp_t             b_resp_q, b_resp_d;
  logic                  aw_hs, w_hs, wr_commit, mem_we;
  logic [AXI_ADDR_W-1:0] wr_addr_eff, wr_off;
  logic [AXI_DATA_W-1:0] wr_data_eff;
  logic [AXI_STRB_W-1:0] wr_strb_eff;
  logic                  wr_hit;
  logic [IDX_W-1:0]      wr_idx;

  assign aw_ready_o = rdy_en_q && (wr_state_q == W_IDLE) && !aw_got_q;
  assign w_ready_o  = rdy_en_q && (wr_state_q == W_IDLE) && !w_got_q;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  assign b_valid_o  = (wr_state_q == W_RESP);
  assign b_resp_o   = b_resp_q;

  // Whichever half arrives last is used straight from the bus.
  assign wr_addr_eff = aw_got_q ? aw_addr_q : aw_addr_i;
  assign wr_data_eff = w_got_q ? w_data_q : w_data_i;
  assign wr_strb_eff = w_got_q ? w_strb_q : w_strb_i;
  assign wr_off      = wr_addr_eff - ADDR_BASE;
  assign wr_hit      = wr_off < SPAN;
  assign wr_idx      = wr_off[IDX_W+1:2];
  assign mem_we      = wr_commit && wr_hit;

  // Write next-state: collect AW and W in any order, commit, delay, then hold B.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          aw_addr_d = aw_addr_i;
        end
        if (w_hs) begin
          w_got_d  = 1'b1;
          w_data_d = w_data_i;
          w_strb_d = w_strb_i;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_commit  = 1'b1;
          wr_cnt_d   = dly;
          b_resp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = (dly == 4'd0) ? W_RESP : W_DLY;
        end
      end
      W_DLY: begin
        wr_cnt_d = wr_cnt_q - 4'd1;
        if (wr_cnt_q <= 4'd1) wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_ready_i) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write path registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Word array, byte-lane writes on a decoded hit.
  // NOTE: the array has no reset; clearing thousands of words would need a reset sequencer, and contents are preloaded.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_idx] <= strb_merge(mem_q[wr_idx], wr_data_eff, wr_strb_eff);
  end

endmodule

// File: tb/tb_axi_lite_responder.sv
// Self-checking bench: instance 0 uses a fixed delay of 2, instance 1 the LFSR delay.
module tb_axi_lite_responder;
  import axi_lite_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ar_valid [2];
  logic [31:0] ar_addr  [2];
  logic        ar_ready [2];
  logic        r_valid  [2];
  logic [31:0] r_data   [2];
  axi_resp_t   r_resp   [2];
  logic        r_ready  [2];
  logic        aw_valid [2];
  logic [31:0] aw_addr  [2];
  logic        aw_ready [2];
  logic        w_valid  [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  logic        w_ready  [2];
  logic        b_valid  [2];
  axi_resp_t   b_resp   [2];
  logic        b_ready  [2];

  axi_lite_responder #(.RAND_DLY(1'b0), .FIXED_DLY(2)) u_fix (
    .clk_i(clk), .rst_i(rst_n),
    .ar_valid_i(ar_valid[0]), .ar_addr_i(ar_addr[0]), .ar_ready_o(ar_ready[0]),
    .r_valid_o(r_valid[0]), .r_data_o(r_data[0]), .r_resp_o(r_resp[0]), .r_ready_i(r_ready[0]),
    .aw_valid_i(aw_valid[0]), .aw_addr_i(aw_addr[0]), .aw_ready_o(aw_ready[0]),
    .w_valid_i(w_valid[0]), .w_data_i(w_data[0]), .w_strb_i(w_strb[0]), .w_ready_o(w_ready[0]),
    .b_valid_o(b_valid[0]), .b_resp_o(b_resp[0]), .b_ready_i(b_ready[0])
  );

  axi_lite_responder #(.RAND_DLY(1'b1)) u_rnd (
    .clk_i(clk), .rst_i(rst_n),
    .ar_valid_i(ar_valid[1]), .ar_addr_i(ar_addr[1]), .ar_ready_o(ar_ready[1]),
    .r_valid_o(r_valid[1]), .r_data_o(r_data[1]), .r_resp_o(r_resp[1]), .r_ready_i(r_ready[1]),
    .aw_valid_i(aw_valid[1]), .aw_addr_i(aw_addr[1]), .aw_ready_o(aw_ready[1]),
    .w_valid_i(w_valid[1]), .w_data_i(w_data[1]), .w_strb_i(w_strb[1]), .w_ready_o(w_ready[1]),
    .b_valid_o(b_valid[1]), .b_resp_o(b_resp[1]), .b_ready_i(b_ready[1])
  );

  int errors = 0;
  int checks = 0;
  int hs_dly;

  // Reference model: word array per instance and the delay polynomial stepped every cycle.
  logic [31:0] mem_m [2][4096];
  logic [7:0]  lfsr_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off[11:0]);
  endfunction

  function automatic int dly_now(input int u);
    return (u == 0) ? 2 : int'(lfsr_m[3:0]);
  endfunction

  // All handshake tasks start and end on a falling edge.
  task automatic ar_hs(input int u, input logic [31:0] a);
    int n = 0;
    ar_valid[u] = 1'b1;
    ar_addr[u]  = a;
    while (!ar_ready[u] && n < 50) begin @(negedge clk); n++; end
    check("ar_hs_bound", 32'(n < 50), 32'd1);
    hs_dly = dly_now(u);
    @(negedge clk);
    ar_valid[u] = 1'b0;
  endtask

  task automatic aw_hs(input int u);
    int n = 0;
    aw_valid[u] = 1'b1;
    while (!aw_ready[u] && n < 50) begin @(negedge clk); n++; end
    check("aw_hs_bound", 32'(n < 50), 32'd1);
    hs_dly = dly_now(u);
    @(negedge clk);
    aw_valid[u] = 1'b0;
  endtask

  task automatic w_hs(input int u);
    int n = 0;
    w_valid[u] = 1'b1;
    while (!w_ready[u] && n < 50) begin @(negedge clk); n++; end
    check("w_hs_bound", 32'(n < 50), 32'd1);
    hs_dly = dly_now(u);
    @(negedge clk);
    w_valid[u] = 1'b0;
  endtask

  task automatic wait_rv(input int u, output int lat);
    lat = 1;
    while (!r_valid[u] && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_bv(input int u, output int lat);
    lat = 1;
    while (!b_valid[u] && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic model_read(input int u, input logic [31:0] a,
                            output logic [31:0] d, output logic [31:0] rsp);
    d   = m_hit(a) ? mem_m[u][m_idx(a)] : 32'h0;
    rsp = m_hit(a) ? 32'd0 : 32'd2;
  endtask

  task automatic do_read(input int u, input logic [31:0] a);
    int lat;
    logic [31:0] exp_d, exp_r;
    ar_hs(u, a);
    wait_rv(u, lat);
    check("r_latency", 32'(lat), 32'(hs_dly + 1));
    if (u == 1) check("r_latency_range", 32'(lat >= 1 && lat <= 16), 32'd1);
    model_read(u, a, exp_d, exp_r);
    check("r_data", r_data[u], exp_d);
    check("r_resp", 32'(r_resp[u]), exp_r);
    @(negedge clk);
    check("r_single", 32'(r_valid[u]), 32'd0);
    check("ar_ready_back", 32'(ar_ready[u]), 32'd1);
  endtask

  // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap = idle cycles between them.
  task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int order, input int gap);
    int lat;
    logic [31:0] exp_r;
    aw_addr[u] = a;
    w_data[u]  = d;
    w_strb[u]  = s;
    if (order == 0) begin
      aw_valid[u] = 1'b1;
      w_valid[u]  = 1'b1;
      check("aw_w_ready_together", {30'd0, aw_ready[u], w_ready[u]}, 32'd3);
      hs_dly = dly_now(u);
      @(negedge clk);
      aw_valid[u] = 1'b0;
      w_valid[u]  = 1'b0;
    end else if (order == 1) begin
      w_hs(u);
      check("w_ready_after_w", 32'(w_ready[u]), 32'd0);
      check("aw_ready_after_w", 32'(aw_ready[u]), 32'd1);
      repeat (gap) @(negedge clk);
      aw_hs(u);
    end else begin
      aw_hs(u);
      check("aw_ready_after_aw", 32'(aw_ready[u]), 32'd0);
      check("w_ready_after_aw", 32'(w_ready[u]), 32'd1);
      repeat (gap) @(negedge clk);
      w_hs(u);
    end
    wait_bv(u, lat);
    check("b_latency", 32'(lat), 32'(hs_dly + 1));
    exp_r = m_hit(a) ? 32'd0 : 32'd2;
    if (m_hit(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[u][m_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
    check("b_resp", 32'(b_resp[u]), exp_r);
    @(negedge clk);
    check("b_single", 32'(b_valid[u]), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] v, a, exp_d, exp_r;
    bit stable, quiet;

    for (int u = 0; u < 2; u++) begin
      ar_valid[u] = 1'b0; ar_addr[u] = '0; r_ready[u] = 1'b1;
      aw_valid[u] = 1'b0; aw_addr[u] = '0; w_valid[u] = 1'b0;
      w_data[u] = '0; w_strb[u] = '0; b_ready[u] = 1'b1;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ar_ready", 32'(ar_ready[u]), 32'd0);
      check("rst_aw_ready", 32'(aw_ready[u]), 32'd0);
      check("rst_w_ready", 32'(w_ready[u]), 32'd0);
      check("rst_r_valid", 32'(r_valid[u]), 32'd0);
      check("rst_b_valid", 32'(b_valid[u]), 32'd0);
      check("rst_r_data", r_data[u], 32'd0);
      check("rst_r_resp", 32'(r_resp[u]), 32'd0);
      check("rst_b_resp", 32'(b_resp[u]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_gated_after_release", 32'(ar_ready[0]), 32'd0);
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      check("ready_after_release", {29'd0, ar_ready[u], aw_ready[u], w_ready[u]}, 32'd7);

    // Preload words 0..31 of both instances.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 32; i++) begin
        v = (i == 0) ? 32'hDEAD_BEEF : (i == 4) ? 32'h0 : $urandom;
        do_write(u, BASE + 32'(4 * i), v, 4'hF, 0, 0);
      end
    end

    // Fixed delay read: three cycles, DEADBEEF, OKAY.
    do_read(0, BASE);
    check("fixed_read_const", mem_m[0][0], 32'hDEAD_BEEF);

    // Byte strobes.
    do_write(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0);
    do_read(0, 32'h8000_0010);
    check("strb_model_const", mem_m[0][4], 32'h0022_0044);

    // AW/W ordering: W first by 3, AW first by 3, then together.
    do_write(0, BASE + 32'h14, 32'hA5A5_0001, 4'hF, 1, 3);
    do_write(0, BASE + 32'h18, 32'hA5A5_0002, 4'b0011, 2, 3);
    do_write(0, BASE + 32'h1C, 32'hA5A5_0003, 4'b1100, 0, 0);
    do_read(0, BASE + 32'h14);
    do_read(0, BASE + 32'h18);
    do_read(0, BASE + 32'h1C);

    // Decode edges: below base, one past the end, unaligned low bits, last word.
    do_read(0, 32'h7FFF_FFFC);
    do_read(0, 32'h8000_4000);
    do_write(0, 32'h8000_4000, 32'hBAD0_BAD0, 4'hF, 0, 0);
    do_read(0, BASE);
    do_read(0, 32'h8000_0003);
    do_write(0, 32'h8000_3FFC, 32'h0F0F_1234, 4'hF, 2, 1);
    do_read(0, 32'h8000_3FFC);

    // Backpressure: response held for 10 cycles without R handshake.
    r_ready[0] = 1'b0;
    ar_hs(0, BASE + 32'h4 * 32'd9);
    wait_rv(0, lat);
    check("bp_latency", 32'(lat), 32'd3);
    model_read(0, BASE + 32'h4 * 32'd9, exp_d, exp_r);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(r_valid[0] === 1'b1 && r_data[0] === exp_d && ar_ready[0] === 1'b0)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_data", r_data[0], exp_d);
    r_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_released", 32'(r_valid[0]), 32'd0);

    // Reset during R_WAIT: no response ever appears.
    ar_hs(0, BASE);
    rst_n = 1'b0;
    #1;
    check("rst_wait_r_valid", 32'(r_valid[0]), 32'd0);
    check("rst_wait_ar_ready", 32'(ar_ready[0]), 32'd0);
    check("rst_wait_r_data", r_data[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r_valid[0] !== 1'b0) quiet = 1'b0;
    end
    check("rst_wait_dropped", 32'(quiet), 32'd1);

    // Reset during R_RESP: r_valid drops at once.
    r_ready[0] = 1'b0;
    ar_hs(0, BASE + 32'h8);
    wait_rv(0, lat);
    check("rst_resp_valid_before", 32'(r_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid_drop", 32'(r_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r_ready[0] = 1'b1;
    @(negedge clk);
    do_read(0, BASE + 32'h8);

    // Random traffic on the LFSR-delay instance.
    for (int k = 0; k < 200; k++) begin
      a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, 1) ? 32'h8000_4000 + 32'(4 * $urandom_range(0, 7)) : 32'h7FFF_FFF0;
      if ($urandom_range(0, 2) == 0)
        do_write(1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
      do_read(1, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
